// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and write-port arbitration
// for the multi-port register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  localparam int REG_ZERO  = 0;
  localparam int MAX_NW    = 2;

  typedef logic [MAX_NW-1:0] whit_t;

  typedef struct packed {
    logic hit;
    logic idx;
  } wsel_t;

  // Highest-index hitting port wins the address.
  function automatic wsel_t win_port(input whit_t hit);
    wsel_t s;
    s.hit = |hit;
    s.idx = hit[1];
    return s;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for
// multi-cycle producers; a new set beats a retiring write.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] clr_i,
  input  logic             set_i,
  input  logic [AW-1:0]    addr_i,
  output logic [DEPTH-1:0] busy_o
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clear on write, then set on bset; x0 never busy.
  always_comb begin
    busy_d = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (a != REG_ZERO) begin
        busy_d[a] = (set_i && (addr_i == AW'(a)))
                  || (busy_q[a] && !clr_i[a]);
      end
    end
  end

  // Busy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: parametrised multi-port register file
// with optional write bypass, zero register and scoreboard.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int NR     = 2,
  parameter  int NW     = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NW-1:0]     we,
  input  logic [NW*AW-1:0]  wa,
  input  logic [NW*XLEN-1:0] wd,
  input  logic [NR*AW-1:0]  ra,
  output logic [NR*XLEN-1:0] rd,
  output logic [NR-1:0]     rd_busy,
  input  logic              bset,
  input  logic [AW-1:0]     baddr,
  output logic [DEPTH-1:0]  busy_vec
);

  logic [XLEN-1:0]  regs_q [DEPTH];
  logic [XLEN-1:0]  regs_d [DEPTH];
  whit_t            hit_w  [DEPTH];
  wsel_t            ws_w   [DEPTH];
  logic [DEPTH-1:0] wclr;

  // Per-address port hits and the winning port.
  always_comb begin
    wclr = '0;
    for (int a = 0; a < DEPTH; a++) begin
      hit_w[a] = '0;
      for (int k = 0; k < NW; k++) begin
        hit_w[a][k] = we[k]
                    && (wa[k*AW +: AW] == AW'(a));
      end
      ws_w[a] = win_port(hit_w[a]);
      wclr[a] = (a != REG_ZERO) && ws_w[a].hit;
    end
  end

  // Next-state storage; x0 is never written.
  always_comb begin
    for (int a = 0; a < DEPTH; a++) begin
      regs_d[a] = regs_q[a];
      if (wclr[a]) begin
        regs_d[a] = wd[int'(ws_w[a].idx)*XLEN +: XLEN];
      end
    end
  end

  // Register array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_q[a] <= '0;
      end
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_q[a] <= regs_d[a];
      end
    end
  end

  // Combinational read ports with optional bypass.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int j = 0; j < NR; j++) begin
      rd_busy[j] = busy_vec[ra[j*AW +: AW]];
      if (ra[j*AW +: AW] == AW'(REG_ZERO)) begin
        rd[j*XLEN +: XLEN] = '0;
      end else if ((BYPASS != 0)
                   && ws_w[ra[j*AW +: AW]].hit) begin
        rd[j*XLEN +: XLEN] =
          wd[int'(ws_w[ra[j*AW +: AW]].idx)*XLEN +: XLEN];
      end else begin
        rd[j*XLEN +: XLEN] = regs_q[ra[j*AW +: AW]];
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (wclr),
    .set_i  (bset),
    .addr_i (baddr),
    .busy_o (busy_vec)
  );

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-cycle CPU's 32x32 register file.
- Adds the following:
  - configurable data width, depth, read-port count and write-port count;
  - an optional same-cycle write-to-read bypass;
  - a hardwired zero register;
  - a per-register busy scoreboard for multi-cycle producers.
- Sits between decode (read addresses) and writeback (write ports) of the next-generation datapath.

Parameters:
- XLEN, 32, data width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, not overridden.
- NR, 2, number of read ports, 1 to 4.
- NW, 2, number of write ports, 1 to 2.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- we  input  NW  per-write-port enable.
- wa  input  NW*AW  write addresses; port k is bits [k*AW +: AW].
- wd  input  NW*XLEN  write data; port k is bits [k*XLEN +: XLEN].
- ra  input  NR*AW  read addresses; port j is bits [j*AW +: AW].
- rd  output  NR*XLEN  read data, combinational.
- rd_busy  output  NR  busy flag of the register addressed by each read port.
- bset  input  1  marks register baddr busy (an issued long-latency producer).
- baddr  input  AW  register to mark busy.
- busy_vec  output  DEPTH  scoreboard state, registered.

Behaviour:
- Reset (async, rst_n=0):
  - all DEPTH registers clear to 0; busy_vec clears to 0.
  - rd and rd_busy then read 0 (BYPASS=0 or we=0); with BYPASS=1, rd forwards any enabled write data asynchronously (see bypass rules below); rd_busy reads 0 regardless.
  - Reset mid-operation discards any pending writes and busy marks that cycle.
- Register 0:
  - always reads 0; writes to address 0 are ignored.
  - bset with baddr=0 is ignored; busy_vec[0] is constantly 0.
- Write, at posedge clk:
  - for each k with we[k]=1 and wa[k]!=0, reg[wa[k]] <= wd[k].
  - Two ports writing the same address: the higher port index wins (port 1 over port 0).
- Read is combinational:
  - rd[j] = 0 if ra[j]==0.
  - Else, if BYPASS=1 and some enabled write port targets ra[j], rd[j] = that port's wd, using the highest index if both ports match.
  - Else rd[j] = reg[ra[j]].
  - Zero latency; the stored value appears from the cycle after the write edge.
- Scoreboard, at posedge clk for each address a!=0:
  - the flag is cleared when any enabled write targets a;
  - it is then set if bset=1 and baddr==a.
  - So set and write on the same address in the same cycle leave busy=1: a new producer supersedes the retiring one.
  - rd_busy[j] = busy_vec[ra[j]]. It is not bypassed: a write this cycle does not clear rd_busy until the next cycle.
- No wrap or overflow conditions. Out-of-range addresses cannot occur because DEPTH is a power of two.
- Any number of read ports may alias the same address.

Decomposition:
- Shared package regfile_pkg:
  - REG_ZERO address constant;
  - default XLEN and DEPTH;
  - a function returning the winning write-port index for an address, used by both the write and bypass logic.
- One sub-module, regfile_scoreboard: busy bit-vector storage plus set/clear priority.
- Storage and the read mux stay in the top module.

Test Plan:
- Reset visibility: assert rst_n=0 mid-run after writing 0xDEADBEEF to x5 -> rd for x5 reads 0 immediately, with no clock edge, and busy_vec==0.
- Basic write/read: write 0x12345678 to x4 via port 0, with ra0=4 and ra1=0 -> next cycle rd0=0x12345678, rd1=0. A write of 0xFFFFFFFF to x0 leaves rd reading 0.
- Bypass: with BYPASS=1, write 0xA5A5A5A5 to x7 and read ra0=7 in the same cycle -> rd0=0xA5A5A5A5 before the edge. With BYPASS=0 and the same stimulus -> rd0 shows the old value, then 0xA5A5A5A5 after the edge.
- Port collision: port0 writes 0x11111111 and port1 writes 0x22222222, both to x9 -> x9=0x22222222, and the bypassed read also returns 0x22222222.
- Scoreboard: bset with baddr=3 -> busy_vec[3]=1 and rd_busy for ra=3 is 1. A write to x3 clears it next cycle. Simultaneous bset=3 and write x3 -> busy stays 1. bset with baddr=0 -> busy_vec[0] stays 0.
- Randomised sweep against a reference array: 2,000 cycles with NR=4, NW=2, random we/wa/wd/bset -> every rd and rd_busy matches the model each cycle, for both BYPASS settings.
